router_pkt_src: RTL and testbench
=================================

ROUTER_PKT_SRC -- requirements
Module: router_pkt_src

Interface
REQ-001 Parameter GAP_CYC, default 3, minimum idle cycles with pkt_valid=0 between packets (range 1..15).
REQ-002 Parameter FORCE_SEED, default 8'h01, substitute seed used when seed input is 8'h00.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request one packet; sampled only in IDLE.
REQ-006 addr  input  2  destination port 0..2; 3 is illegal.
REQ-007 len  input  6  payload byte count 1..63; 0 is illegal.
REQ-008 seed  input  8  LFSR seed for payload bytes.
REQ-009 bad_par  input  1  when 1 at start, transmitted parity byte is inverted (error injection).
REQ-010 busy  input  1  router stall; when 1, the presented byte is not consumed.
REQ-011 data_out  output  8  packet byte toward router.
REQ-012 pkt_valid  output  1  high for header and payload bytes, low for parity byte.
REQ-013 tx_busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse when the parity byte is consumed.
REQ-015 req_err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-016 States: IDLE, HDR, PLD, PAR, GAP; data_out and pkt_valid are registered.
REQ-017 Byte consumed = rising edge with state in {HDR,PLD,PAR} and busy=0; with busy=1, data_out, pkt_valid, counters, LFSR and parity hold.
REQ-018 IDLE, start=1, legal addr/len: capture addr, len, seed (or FORCE_SEED), bad_par; next cycle state HDR, data_out={len,addr}, pkt_valid=1.
REQ-019 IDLE, start=1, addr=3 or len=0: req_err=1 next cycle, state stays IDLE, outputs unchanged.
REQ-020 start while not IDLE is ignored with no req_err.
REQ-021 HDR consumed: state PLD, data_out=first payload byte (= captured seed), pkt_valid=1, remaining count=len.
REQ-022 Payload byte k+1 = LFSR step of byte k: next={cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]}.
REQ-023 PLD consumed with remaining count>1: decrement count, present next LFSR byte.
REQ-024 PLD consumed with remaining count=1: state PAR, data_out=parity, pkt_valid=0.
REQ-025 Parity = XOR of header and all len payload bytes, inverted if captured bad_par=1.
REQ-026 PAR consumed: done=1 for one cycle, state GAP, pkt_valid=0, data_out=8'h00.
REQ-027 GAP lasts exactly GAP_CYC cycles regardless of busy, then IDLE; start during GAP is ignored.
REQ-028 Back-to-back start: earliest next header appears GAP_CYC+1 cycles after done.
REQ-029 pkt_valid never glitches low inside header/payload; busy stalls of any length are legal.

Reset
REQ-030 rst=1 forces immediately, without waiting for clk: state IDLE, data_out=8'h00, pkt_valid=0, tx_busy=0, done=0, req_err=0, counters/LFSR/parity cleared.
REQ-031 Reset mid-packet abandons the packet; after release, no residual bytes are emitted and the next legal start sends a full packet.

Structure
REQ-032 Shared package router_pkg holds the state enumeration, header field widths (ADDR_W=2, LEN_W=6), the illegal address constant, and the LFSR tap definition.
REQ-033 One sub-module, router_lfsr8, with load, enable and seed inputs and an 8-bit state output; the FSM, counter and parity logic stay in router_pkt_src.

Verification
REQ-034 addr=1, len=3, seed=8'h01, busy=0 -> data_out 0x0D,0x01,0x02,0x04 with pkt_valid=1, then 0x0A with pkt_valid=0, done pulse.
REQ-035 Same packet with busy=1 for 4 cycles during the second payload byte -> 0x02 held for 5 cycles, byte sequence and parity unchanged.
REQ-036 start with addr=3, then with len=0 -> req_err pulses twice, tx_busy stays 0, pkt_valid stays 0.
REQ-037 Same packet as REQ-034 with bad_par=1 -> parity byte 0xF5, done pulses.
REQ-038 rst asserted asynchronously during payload of a len=63 packet -> pkt_valid=0 within the same cycle; a subsequent start with addr=2, len=1, seed=0 sends 0x06,0x01,0x07.
REQ-039 start held high continuously, GAP_CYC=3 -> consecutive headers are exactly 3 idle cycles after the prior parity byte plus 1 start cycle, and no packet is lost or duplicated.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router packet source: FSM states, header field
// widths, the reserved destination address and the payload LFSR taps.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;

  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'd3;

  // Feedback taps on bits 7, 5, 4 and 3; the feedback bit shifts in at bit 0.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PLD,
    ST_PAR,
    ST_GAP
  } state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/router_lfsr8.sv
// 8-bit payload LFSR: load takes priority over enable; state holds otherwise.
module router_lfsr8
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       enable,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= 8'h00;
    end else if (load) begin
      state <= seed;
    end else if (enable) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/router_pkt_src.sv
// Packet source: emits header {len,addr}, len LFSR payload bytes and an XOR
// parity byte toward the router, honouring busy stalls and an inter-packet gap.
module router_pkt_src
  import router_pkg::*;
#(
  parameter int         GAP_CYC    = 3,
  parameter logic [7:0] FORCE_SEED = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [7:0]        seed,
  input  logic              bad_par,
  input  logic              busy,
  output logic [7:0]        data_out,
  output logic              pkt_valid,
  output logic              tx_busy,
  output logic              done,
  output logic              req_err
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYC - 1);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count;
  logic [3:0]        gap_cnt;
  logic [7:0]        par;
  logic              bad_q;

  logic              legal;
  logic              consumed;
  logic              lfsr_load;
  logic              lfsr_en;
  logic [7:0]        seed_eff;
  logic [7:0]        lfsr_state;

  always_comb begin
    legal     = (addr != ADDR_ILLEGAL) && (len != '0);
    consumed  = !busy && (state == ST_HDR || state == ST_PLD || state == ST_PAR);
    lfsr_load = (state == ST_IDLE) && start && legal;
    // The LFSR runs one byte ahead of data_out, so it advances each time a
    // payload byte is put on the bus.
    lfsr_en   = consumed && (state == ST_HDR || (state == ST_PLD && count > 6'd1));
    seed_eff  = (seed == 8'h00) ? FORCE_SEED : seed;
  end

  router_lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .enable (lfsr_en),
    .seed   (seed_eff),
    .state  (lfsr_state)
  );

  assign tx_busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      data_out  <= 8'h00;
      pkt_valid <= 1'b0;
      done      <= 1'b0;
      req_err   <= 1'b0;
      len_q     <= '0;
      count     <= '0;
      gap_cnt   <= '0;
      par       <= 8'h00;
      bad_q     <= 1'b0;
    end else begin
      done    <= 1'b0;
      req_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (legal) begin
              state     <= ST_HDR;
              data_out  <= {len, addr};
              pkt_valid <= 1'b1;
              len_q     <= len;
              bad_q     <= bad_par;
              par       <= {len, addr};
            end else begin
              req_err <= 1'b1;
            end
          end
        end
        ST_HDR: begin
          if (!busy) begin
            state    <= ST_PLD;
            data_out <= lfsr_state;
            par      <= par ^ lfsr_state;
            count    <= len_q;
          end
        end
        ST_PLD: begin
          if (!busy) begin
            if (count > 6'd1) begin
              data_out <= lfsr_state;
              par      <= par ^ lfsr_state;
              count    <= count - 6'd1;
            end else begin
              state     <= ST_PAR;
              data_out  <= par ^ {8{bad_q}};
              pkt_valid <= 1'b0;
            end
          end
        end
        ST_PAR: begin
          if (!busy) begin
            state    <= ST_GAP;
            data_out <= 8'h00;
            done     <= 1'b1;
            gap_cnt  <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// Self-checking bench for router_pkt_src: scoreboard of expected bus bytes,
// one task per scenario, summary line at the end.
module tb_router_pkt_src;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] addr;
  logic [5:0] len;
  logic [7:0] seed;
  logic       bad_par;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_busy;
  logic       done;
  logic       req_err;

  typedef struct {
    logic [7:0] data;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  router_pkt_src #(
    .GAP_CYC    (3),
    .FORCE_SEED (8'h01)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr      (addr),
    .len       (len),
    .seed      (seed),
    .bad_par   (bad_par),
    .busy      (busy),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .tx_busy   (tx_busy),
    .done      (done),
    .req_err   (req_err)
  );

  function automatic logic [7:0] model_step(input logic [7:0] c);
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

  task automatic push_expected(input logic [1:0] a, input logic [5:0] l,
                               input logic [7:0] s, input logic b);
    logic [7:0] hdr;
    logic [7:0] p;
    logic [7:0] cur;
    hdr = {l, a};
    p   = hdr;
    exp_q.push_back('{data: hdr, valid: 1'b1});
    cur = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back('{data: cur, valid: 1'b1});
      p   = p ^ cur;
      cur = model_step(cur);
    end
    exp_q.push_back('{data: p ^ {8{b}}, valid: 1'b0});
  endtask

  // Drives a one-cycle start at a falling edge; returns at the next falling
  // edge, where the header should already be on the bus.
  task automatic start_pkt(input logic [1:0] a, input logic [5:0] l,
                           input logic [7:0] s, input logic b);
    addr    = a;
    len     = l;
    seed    = s;
    bad_par = b;
    start   = 1'b1;
    push_expected(a, l, s, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (data_out !== 8'h00 || pkt_valid !== 1'b0 || tx_busy !== 1'b0 ||
        done !== 1'b0 || req_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got data=%h valid=%b busy=%b done=%b err=%b, expected 00 0 0 0 0",
               data_out, pkt_valid, tx_busy, done, req_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    exp_t e;
    int   guard;
    for (int bp = 0; bp < 2; bp++) begin
      start_pkt(2'd1, 6'd3, 8'h01, bp[0]);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (data_out !== e.data || pkt_valid !== e.valid) begin
          errors++;
          $display("[TB] FAIL basic_byte bad_par=%0d: got %h/%b, expected %h/%b",
                   bp, data_out, pkt_valid, e.data, e.valid);
        end
        @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("[TB] FAIL basic_done: got %b, expected 1", done);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_done_width: got %b, expected 0", done);
      end
      guard = 0;
      while (tx_busy && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (tx_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_idle: got tx_busy=%b, expected 0", tx_busy);
      end
    end
  endtask

  task automatic test_stall;
    exp_t e;
    int   popped;
    int   held;
    int   guard;
    start_pkt(2'd1, 6'd3, 8'h01, 1'b0);
    popped = 0;
    held   = 0;
    guard  = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      busy = (popped == 2 && held < 4);
      if (busy) begin
        held++;
        checks++;
        if (data_out !== exp_q[0].data || pkt_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stall_hold cycle %0d: got %h/%b, expected %h/1",
                   held, data_out, pkt_valid, exp_q[0].data);
        end
      end else begin
        e = exp_q.pop_front();
        popped++;
        checks++;
        if (data_out !== e.data || pkt_valid !== e.valid) begin
          errors++;
          $display("[TB] FAIL stall_byte %0d: got %h/%b, expected %h/%b",
                   popped, data_out, pkt_valid, e.data, e.valid);
        end
      end
      @(negedge clk);
      guard++;
    end
    busy = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_done: got %b, expected 1", done);
    end
    guard = 0;
    while (tx_busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_idle: got tx_busy=%b, expected 0", tx_busy);
    end
  endtask

  task automatic test_reject;
    for (int i = 0; i < 2; i++) begin
      addr  = (i == 0) ? 2'd3 : 2'd1;
      len   = (i == 0) ? 6'd5 : 6'd0;
      seed  = 8'h33;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (req_err !== 1'b1 || tx_busy !== 1'b0 || pkt_valid !== 1'b0 || data_out !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reject_%0d: got err=%b busy=%b valid=%b data=%h, expected 1 0 0 00",
                 i, req_err, tx_busy, pkt_valid, data_out);
      end
      @(negedge clk);
      checks++;
      if (req_err !== 1'b0 || tx_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reject_pulse_%0d: got err=%b busy=%b, expected 0 0", i, req_err, tx_busy);
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   bad_cycles;
    start_pkt(2'd0, 6'd63, 8'h5A, 1'b0);
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (data_out !== e.data || pkt_valid !== e.valid) begin
        errors++;
        $display("[TB] FAIL long_byte %0d: got %h/%b, expected %h/%b",
                 i, data_out, pkt_valid, e.data, e.valid);
      end
      @(negedge clk);
    end
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pkt_valid !== 1'b0 || tx_busy !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset: got valid=%b busy=%b data=%h, expected 0 0 00",
               pkt_valid, tx_busy, data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    bad_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pkt_valid !== 1'b0 || tx_busy !== 1'b0) bad_cycles++;
    end
    checks++;
    if (bad_cycles != 0) begin
      errors++;
      $display("[TB] FAIL residual_bytes: got %0d active cycles after reset, expected 0", bad_cycles);
    end
    start_pkt(2'd2, 6'd1, 8'h00, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (data_out !== e.data || pkt_valid !== e.valid) begin
        errors++;
        $display("[TB] FAIL post_reset_byte: got %h/%b, expected %h/%b",
                 data_out, pkt_valid, e.data, e.valid);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_done: got %b, expected 1", done);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   stray;
    repeat (6) @(negedge clk);
    addr    = 2'd1;
    len     = 6'd3;
    seed    = 8'h01;
    bad_par = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      push_expected(2'd1, 6'd3, 8'h01, 1'b0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (data_out !== e.data || pkt_valid !== e.valid || req_err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_byte pkt %0d: got %h/%b err=%b, expected %h/%b err=0",
                   p, data_out, pkt_valid, req_err, e.data, e.valid);
        end
        @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_done pkt %0d: got %b, expected 1", p, done);
      end
      if (p == 2) start = 1'b0;
      if (p < 2) begin
        for (int c = 0; c < 4; c++) begin
          checks++;
          if (pkt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_gap pkt %0d cycle %0d: got valid=%b, expected 0", p, c, pkt_valid);
          end
          @(negedge clk);
        end
      end
    end
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pkt_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0 || tx_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_extra_packet: got %0d valid cycles busy=%b, expected 0 0", stray, tx_busy);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    addr    = 2'd0;
    len     = 6'd0;
    seed    = 8'h00;
    bad_par = 1'b0;
    busy    = 1'b0;
    $display("[TB] starting router_pkt_src bench");
    test_reset();
    test_basic();
    test_stall();
    test_reject();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
